// File: rtl/jstk2_spi_responder.sv
// jstk2_spi_responder: SPI mode-0 slave emulating the PmodJSTK2 joystick.
// Returns a position/button frame and, when JSTK2_RESP_LED_CMD_EN is defined,
// decodes the set-RGB-LED command (0x84) sent by the master.
`timescale 1ns/1ps
module jstk2_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        SS,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        trigger,
    input  logic        jstk_btn,
    output logic [23:0] led_rgb,
    output logic        led_valid,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [2:0] LP_NBYTES = 3'(FRAME_BYTES);
    localparam logic [5:0] LP_NBITS  = 6'(FRAME_BYTES * 8);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;
    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
    logic       r_sclk_q, r_ss_q;
    logic       w_sclk_s, w_ss_s;
    logic       w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

    logic [9:0] r_snap_x, r_snap_y;
    logic       r_snap_t, r_snap_b;
    logic [7:0] r_shift, w_tx_byte;
    logic [2:0] r_bit_cnt, r_byte_idx;
    logic [5:0] r_total;
    logic       r_frame_done, r_frame_err;

    // SS idles high so a reset never fakes a select edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_q    <= 1'b0;
            r_ss_q      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_q    <= w_sclk_s;
            r_ss_q      <= w_ss_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_q;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_q;
    assign w_ss_fall   = ~w_ss_s   &  r_ss_q;
    assign w_ss_rise   =  w_ss_s   & ~r_ss_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next state: select opens a frame, deselect closes it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_ss_fall) w_next = S_ACTIVE;
            S_ACTIVE: if (w_ss_rise) w_next = S_IDLE;
        endcase
    end

    // Byte to transmit next; bytes past the frame read as zero.
    always_comb begin
        w_tx_byte = 8'h00;
        if (r_byte_idx < LP_NBYTES) begin
            case (r_byte_idx)
                3'd0:    w_tx_byte = r_snap_x[7:0];
                3'd1:    w_tx_byte = {6'b0, r_snap_x[9:8]};
                3'd2:    w_tx_byte = r_snap_y[7:0];
                3'd3:    w_tx_byte = {6'b0, r_snap_y[9:8]};
                3'd4:    w_tx_byte = {6'b0, r_snap_t, r_snap_b};
                default: w_tx_byte = 8'h00;
            endcase
        end
    end

    // Frame datapath: snapshot, bit counting, MISO shifting, end-of-frame pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap_x     <= '0;
            r_snap_y     <= '0;
            r_snap_t     <= 1'b0;
            r_snap_b     <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_byte_idx   <= '0;
            r_total      <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ss_fall) begin
                        r_snap_x   <= x_pos;
                        r_snap_y   <= y_pos;
                        r_snap_t   <= trigger;
                        r_snap_b   <= jstk_btn;
                        r_shift    <= x_pos[7:0];
                        r_bit_cnt  <= '0;
                        r_byte_idx <= '0;
                        r_total    <= '0;
                    end
                end
                S_ACTIVE: begin
                    // Deselect has priority over any coincident SCLK edge.
                    if (w_ss_rise) begin
                        if (r_total >= LP_NBITS)  r_frame_done <= 1'b1;
                        else if (r_total != 6'd0) r_frame_err  <= 1'b1;
                        r_shift <= '0;
                    end else if (w_sclk_rise) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_total != 6'd63) r_total <= r_total + 6'd1;
                        if (r_bit_cnt == 3'd7 && r_byte_idx != 3'd5)
                            r_byte_idx <= r_byte_idx + 3'd1;
                    end else if (w_sclk_fall) begin
                        if (r_bit_cnt == 3'd0) r_shift <= w_tx_byte;
                        else                   r_shift <= {r_shift[6:0], 1'b0};
                    end
                end
            endcase
        end
    end

    assign MISO       = (r_state == S_ACTIVE) & r_shift[7];
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

`ifdef JSTK2_RESP_LED_CMD_EN
    logic       w_mosi_s;
    logic [7:0] w_rx_byte;
    logic [6:0] r_rx;
    logic [7:0] r_cmd, r_red, r_grn, r_blu;
    logic [23:0] r_led;
    logic       r_led_v;

    assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
    assign w_rx_byte = {r_rx, w_mosi_s};

    // Capture cmd/R/G/B bytes and apply 0x84 at the close of a full frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx    <= '0;
            r_cmd   <= '0;
            r_red   <= '0;
            r_grn   <= '0;
            r_blu   <= '0;
            r_led   <= '0;
            r_led_v <= 1'b0;
        end else begin
            r_led_v <= 1'b0;
            if (r_state == S_ACTIVE) begin
                if (w_ss_rise) begin
                    if (r_total >= LP_NBITS && r_cmd == 8'h84) begin
                        r_led   <= {r_red, r_grn, r_blu};
                        r_led_v <= 1'b1;
                    end
                end else if (w_sclk_rise) begin
                    r_rx <= w_rx_byte[6:0];
                    if (r_bit_cnt == 3'd7) begin
                        case (r_byte_idx)
                            3'd0:    r_cmd <= w_rx_byte;
                            3'd1:    r_red <= w_rx_byte;
                            3'd2:    r_grn <= w_rx_byte;
                            3'd3:    r_blu <= w_rx_byte;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign led_rgb   = r_led;
    assign led_valid = r_led_v;
`else
    logic w_unused_mosi;
    assign w_unused_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign led_rgb   = '0;
    assign led_valid = 1'b0;
`endif

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// tb_jstk2_spi_responder: table-driven frames plus snapshot and reset sequences.
`timescale 1ns/1ps
module tb_jstk2_spi_responder;

`ifdef JSTK2_RESP_LED_CMD_EN
    localparam bit LED_EN = 1'b1;
`else
    localparam bit LED_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0, SCLK = 1'b0, SS = 1'b1, MOSI = 1'b0;
    logic MISO;
    logic [9:0] x_pos = '0, y_pos = '0;
    logic trigger = 1'b0, jstk_btn = 1'b0;
    logic [23:0] led_rgb;
    logic led_valid, frame_done, frame_err;

    always #5 clk = ~clk;

    jstk2_spi_responder #(.SYNC_STAGES(2), .FRAME_BYTES(5)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .x_pos(x_pos), .y_pos(y_pos), .trigger(trigger), .jstk_btn(jstk_btn),
        .led_rgb(led_rgb), .led_valid(led_valid),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    int n_vec = 0, n_mis = 0;
    int n_done = 0, n_err = 0, n_lv = 0, n_lone = 0;
    logic [7:0] sb_q[$];

    // Pulse counters; led_valid must always coincide with frame_done.
    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (frame_err) n_err++;
        if (led_valid) n_lv++;
        if (led_valid && !frame_done) n_lone++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, got no $finish required before 2ms");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [9:0] x, input logic [9:0] y,
                                              input logic t, input logic b, input int k);
        case (k)
            0:       return x[7:0];
            1:       return {6'b0, x[9:8]};
            2:       return y[7:0];
            3:       return {6'b0, y[9:8]};
            4:       return {6'b0, t, b};
            default: return 8'h00;
        endcase
    endfunction

    task automatic push_frame(input logic [9:0] x, input logic [9:0] y,
                              input logic t, input logic b, input int nbytes);
        for (int k = 0; k < nbytes; k++) sb_q.push_back(model_byte(x, y, t, b, k));
    endtask

    task automatic pop_check(input string nm, input logic [63:0] mi, input int nbytes);
        logic [7:0] e;
        for (int k = 0; k < nbytes; k++) begin
            if (sb_q.size() == 0) begin
                chk({nm, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("%s_byte%0d", nm, k), {24'b0, mi[63-8*k -: 8]}, {24'b0, e});
            end
        end
    endtask

    // SPI mode-0 master; MISO is sampled just before each rising edge.
    task automatic spi_xfer(input int nbits, input logic [63:0] mo, input int half,
                            input int chg_bit, input logic [9:0] chg_x, input int rst_bit,
                            output logic [63:0] mi);
        mi = '0;
        SS = 1'b0;
        #(half);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) x_pos = chg_x;
            if (i == rst_bit) begin
                rst = 1'b0;
                #50;
                chk("miso_in_reset", {31'b0, MISO}, 32'd0);
                SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
                #100;
                rst = 1'b1;
                #100;
                return;
            end
            MOSI = mo[63-i];
            #(half);
            mi[63-i] = MISO;
            SCLK = 1'b1;
            #(half);
            SCLK = 1'b0;
        end
        #(half);
        SS = 1'b1;
        MOSI = 1'b0;
        #(half + 200);
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        t;
        logic        b;
        int          nbits;
        logic [63:0] mo;
        int          half;
        int          e_done;
        int          e_err;
        int          e_lv;
        logic [23:0] e_led;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [63:0] mi;
        int d0, e0, l0;
        logic [23:0] led_a, led_b;
        led_a = LED_EN ? 24'hFF1000 : 24'h0;
        led_b = LED_EN ? 24'h123456 : 24'h0;
        tbl[0] = '{10'h2A5, 10'h13C, 1'b1, 1'b0, 40, 64'hC0C0C0C0C0_000000, 500, 1, 0, 0, 24'h0};
        tbl[1] = '{10'h3FF, 10'h000, 1'b0, 1'b1, 40, 64'h84FF100000_000000, 100, 1, 0, int'(LED_EN), led_a};
        tbl[2] = '{10'h155, 10'h2AA, 1'b1, 1'b1, 20, 64'h84AABBCC00_000000, 100, 0, 1, 0, led_a};
        tbl[3] = '{10'h0F0, 10'h30F, 1'b0, 1'b0, 56, 64'hC0C0C0C0C0C0C0_00, 100, 1, 0, 0, led_a};
        tbl[4] = '{10'h000, 10'h3FF, 1'b0, 1'b1, 40, 64'hF0F0F0F0F0_000000, 100, 1, 0, 0, led_a};
        tbl[5] = '{10'h123, 10'h321, 1'b1, 1'b1, 40, 64'h8412345600_000000, 100, 1, 0, int'(LED_EN), led_b};
        tbl[6] = '{10'h3AB, 10'h0CD, 1'b0, 1'b0, 40, 64'h0000000000_000000, 100, 1, 0, 0, led_b};
        tbl[7] = '{10'h1FF, 10'h200, 1'b1, 1'b0, 0,  64'h84FFFFFF00_000000, 100, 0, 0, 0, led_b};

        repeat (3) @(negedge clk);
        chk("rst_miso", {31'b0, MISO}, 32'd0);
        chk("rst_led_rgb", {8'b0, led_rgb}, 32'd0);
        chk("rst_led_valid", {31'b0, led_valid}, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            x_pos = tbl[v].x; y_pos = tbl[v].y;
            trigger = tbl[v].t; jstk_btn = tbl[v].b;
            d0 = n_done; e0 = n_err; l0 = n_lv;
            push_frame(tbl[v].x, tbl[v].y, tbl[v].t, tbl[v].b, tbl[v].nbits / 8);
            spi_xfer(tbl[v].nbits, tbl[v].mo, tbl[v].half, -1, 10'h0, -1, mi);
            pop_check($sformatf("v%0d", v), mi, tbl[v].nbits / 8);
            chk($sformatf("v%0d_done", v), n_done - d0, tbl[v].e_done);
            chk($sformatf("v%0d_err", v), n_err - e0, tbl[v].e_err);
            chk($sformatf("v%0d_led_valid", v), n_lv - l0, tbl[v].e_lv);
            chk($sformatf("v%0d_led_rgb", v), {8'b0, led_rgb}, {8'b0, tbl[v].e_led});
            chk($sformatf("v%0d_miso_idle", v), {31'b0, MISO}, 32'd0);
        end

        // Snapshot stability: x changes mid-frame, visible only next frame.
        x_pos = 10'h000; y_pos = 10'h155; trigger = 1'b0; jstk_btn = 1'b0;
        push_frame(10'h000, 10'h155, 1'b0, 1'b0, 5);
        spi_xfer(40, 64'hC0C0C0C0C0_000000, 100, 3, 10'h3FF, -1, mi);
        pop_check("snap_cur", mi, 5);
        push_frame(10'h3FF, 10'h155, 1'b0, 1'b0, 5);
        spi_xfer(40, 64'hC0C0C0C0C0_000000, 100, -1, 10'h0, -1, mi);
        pop_check("snap_next", mi, 5);

        // Reset mid-frame at bit 17: no pulses, LED cleared, next frame clean.
        x_pos = 10'h2A5; y_pos = 10'h13C; trigger = 1'b1; jstk_btn = 1'b1;
        d0 = n_done; e0 = n_err; l0 = n_lv;
        spi_xfer(40, 64'h84FF100000_000000, 100, -1, 10'h0, 17, mi);
        repeat (20) @(negedge clk);
        chk("rstmid_done", n_done - d0, 0);
        chk("rstmid_err", n_err - e0, 0);
        chk("rstmid_led_valid", n_lv - l0, 0);
        chk("rstmid_led_rgb", {8'b0, led_rgb}, 32'd0);
        d0 = n_done; l0 = n_lv;
        push_frame(10'h2A5, 10'h13C, 1'b1, 1'b1, 5);
        spi_xfer(40, 64'h84ABCDEF00_000000, 100, -1, 10'h0, -1, mi);
        pop_check("post_rst", mi, 5);
        chk("post_rst_done", n_done - d0, 1);
        chk("post_rst_led_valid", n_lv - l0, int'(LED_EN));
        chk("post_rst_led_rgb", {8'b0, led_rgb}, LED_EN ? 32'h00ABCDEF : 32'd0);

        chk("led_valid_alone", n_lone, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/jstk2_spi_responder.md
Name: jstk2_spi_responder

Overview:
- SPI mode-0 slave that emulates the PmodJSTK2 end of the joystick link.
- It answers the codebase's JSTK2 SPI master with a 5-byte position/button frame built from internal values.
- It decodes the master's command byte, including the set-RGB-LED command.
- Used as a bench/loopback stand-in for the physical joystick, and as a second-board joystick emulator driven from switches or a test pattern.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the SCLK/SS/MOSI synchronisers (legal range 2..3).
- FRAME_BYTES, 5, bytes per valid frame.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous reset, active-low.
- SCLK  in  1  SPI clock from master, asynchronous to clk.
- SS  in  1  slave select from master, active-low, asynchronous.
- MOSI  in  1  master-to-slave data, asynchronous.
- MISO  out  1  slave-to-master data.
- x_pos  in  10  X position to report, 0..1023.
- y_pos  in  10  Y position to report, 0..1023.
- trigger  in  1  trigger button state (the master's bumper bit).
- jstk_btn  in  1  joystick press state.
- led_rgb  out  24  last accepted LED command, {R,G,B}.
- led_valid  out  1  one-cycle pulse when led_rgb updates.
- frame_done  out  1  one-cycle pulse after a complete 40-bit frame.
- frame_err  out  1  one-cycle pulse when SS rises after 1..39 bits.

Behaviour:
- Reset (rst=0): all outputs 0, state IDLE, counters 0, snapshot registers 0.
- Synchronisation:
  - SCLK, SS and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised versions.
  - Requirement on the master: SCLK half-period ≥ 4 clk (SCLK ≤ 12.5 MHz).
- State IDLE:
  - MISO=0.
  - Transition on the synchronised SS falling edge:
    - snapshot tx bytes: B0=x_pos[7:0], B1={6'b0,x_pos[9:8]}, B2=y_pos[7:0], B3={6'b0,y_pos[9:8]}, B4={6'b0,trigger,jstk_btn};
    - load shift register with B0 and drive MISO=B0[7] on the same cycle;
    - bit_cnt=0, byte_idx=0; go to ACTIVE.
- State ACTIVE:
  - SCLK rising edge:
    - sample MOSI into rx shift register, MSB first;
    - bit_cnt increments mod 8; total_bits increments, saturating at 63.
    - When bit_cnt wraps 7→0, the completed rx byte is stored per byte_idx (0 = cmd, 1..3 = R,G,B) and byte_idx increments, saturating at 5.
  - SCLK falling edge:
    - if bit_cnt==0 and byte_idx<FRAME_BYTES, load tx byte[byte_idx] and MISO=its MSB;
    - if bit_cnt==0 and byte_idx≥FRAME_BYTES, load 0x00;
    - otherwise shift left and MISO=next bit.
  - MISO changes no later than SYNC_STAGES+1 clk cycles after the SCLK falling edge.
  - Simultaneous detected SCLK edge and SS rise: SS rise wins; the edge is ignored.
- SS rising edge (ACTIVE→IDLE), evaluated against total_bits:
  - total_bits==40: frame_done pulses 1 cycle later.
    - If cmd==0x84, led_rgb <= {R,G,B} and led_valid pulses in the same cycle as frame_done.
  - total_bits in 1..39: frame_err pulses; led_rgb unchanged.
  - total_bits==0: no pulse.
  - total_bits>40: frame_done pulses; extra bits are ignored and extra MISO bytes are 0x00.
  - MISO returns to 0.
- Input changes during a frame do not alter the bytes being sent; they are used at the next SS fall.
- Reset mid-frame: immediate return to IDLE, MISO=0, no pulses.
- Commands other than 0x84 (e.g. 0xC0, 0xF0, 0x00): position frame returned normally, no LED update.

Optional Feature:
- JSTK2_RESP_LED_CMD_EN defined:
  - cmd/RGB capture and 0x84 decode are built;
  - led_rgb and led_valid behave as described above.
- JSTK2_RESP_LED_CMD_EN undefined:
  - no rx byte storage or command decode is built;
  - led_rgb is tied to 0 and led_valid to 0;
  - MOSI is still synchronised but unused;
  - frame_done and frame_err are unaffected.

Test Plan:
- Frame readback: x_pos=10'h2A5, y_pos=10'h13C, trigger=1, jstk_btn=0; master sends 5 bytes 0xC0 at SCLK=1 MHz -> MISO bytes A5,02,3C,01,02; frame_done one pulse; led_valid stays 0.
- LED command: master sends 84,FF,10,00,00 -> frame_done and led_valid pulse together; led_rgb=24'hFF1000.
- Short frame: SS raised after 20 bits -> frame_err one pulse; no frame_done; led_rgb holds its previous value.
- Snapshot stability: x_pos changes 0x000→0x3FF after bit 3 of the frame -> current frame returns 00,00; next frame returns FF,03.
- Overlong frame: 7 bytes clocked -> bytes 6 and 7 read 0x00; frame_done pulses once.
- Reset mid-frame: rst=0 at bit 17, then released; a new full frame follows -> MISO=0 during reset; no pulses from the aborted frame; new frame reads correctly.
